// File: rtl/csr_trap.sv
// csr_trap: architectural CSR state (CRMD..LLBCTL) and commit-stage trap sequencing.
// Define CSR_TIMER_EN to build the stable timer (TID/TCFG/TVAL/TICLR, ESTAT.IS[11]).
module csr_trap #(
    parameter int          TIMER_W   = 32,
    parameter logic [31:0] TID_RESET = 32'h0,
    parameter int          EXC_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [13:0]      csr_read_addr,
    output logic [31:0]      csr_read_data,
    input  logic             csr_write_en,
    input  logic [13:0]      csr_write_addr,
    input  logic [31:0]      csr_write_data,
    input  logic             is_exception,
    input  logic [31:0]      exception_pc,
    input  logic [31:0]      exception_addr,
    input  logic [EXC_W-1:0] exception_cause,
    input  logic [5:0]       ecode,
    input  logic [8:0]       esubcode,
    input  logic             is_ertn,
    input  logic             is_llw_scw,
    input  logic             llbit_value,
    input  logic [7:0]       hw_int,
    output logic [31:0]      crmd,
    output logic [31:0]      ecfg,
    output logic [31:0]      estat,
    output logic [31:0]      era,
    output logic [31:0]      eentry,
    output logic             llbit
);
    localparam logic [13:0] A_CRMD   = 14'h000;
    localparam logic [13:0] A_PRMD   = 14'h001;
    localparam logic [13:0] A_ECFG   = 14'h004;
    localparam logic [13:0] A_ESTAT  = 14'h005;
    localparam logic [13:0] A_ERA    = 14'h006;
    localparam logic [13:0] A_BADV   = 14'h007;
    localparam logic [13:0] A_EENTRY = 14'h00c;
    localparam logic [13:0] A_TID    = 14'h040;
    localparam logic [13:0] A_TCFG   = 14'h041;
    localparam logic [13:0] A_TVAL   = 14'h042;
    localparam logic [13:0] A_TICLR  = 14'h044;
    localparam logic [13:0] A_LLBCTL = 14'h060;

    // exception_cause encoding agreed with the commit controller
    localparam logic [EXC_W-1:0] CAUSE_ADEF = EXC_W'(8);
    localparam logic [EXC_W-1:0] CAUSE_ALE  = EXC_W'(9);
    localparam logic [EXC_W-1:0] CAUSE_ADEM = EXC_W'(10);

    logic [8:0]         crmd_q;
    logic [2:0]         prmd_q;
    logic [12:0]        ecfg_q;
    logic [1:0]         is_sw_q;
    logic [7:0]         is_hw_q;
    logic [5:0]         ecode_q;
    logic [8:0]         esub_q;
    logic [31:0]        era_q;
    logic [31:0]        badv_q;
    logic [25:0]        eentry_q;
    logic               llbit_q;
    logic               klo_q;
    logic               csr_wr;
    logic [31:0]        tid_r;
    logic [TIMER_W-1:0] tcfg_r;
    logic [TIMER_W-1:0] tval_r;
    logic               timer_is;

    // Exception and ertn both own the register file this cycle; a coincident write is lost.
    assign csr_wr = csr_write_en & ~is_exception & ~is_ertn;

    always_ff @(posedge clk) begin
        if (rst) begin
            crmd_q   <= 9'h008;
            prmd_q   <= '0;
            ecfg_q   <= '0;
            is_sw_q  <= '0;
            is_hw_q  <= '0;
            ecode_q  <= '0;
            esub_q   <= '0;
            era_q    <= '0;
            badv_q   <= '0;
            eentry_q <= '0;
            llbit_q  <= 1'b0;
            klo_q    <= 1'b0;
        end else begin
            is_hw_q <= hw_int;
            if (is_exception) begin
                prmd_q      <= crmd_q[2:0];
                crmd_q[2:0] <= 3'b000;
                ecode_q     <= ecode;
                esub_q      <= esubcode;
                era_q       <= exception_pc;
                if (exception_cause == CAUSE_ADEF)
                    badv_q <= exception_pc;
                else if (exception_cause == CAUSE_ALE || exception_cause == CAUSE_ADEM)
                    badv_q <= exception_addr;
                if (ecode == 6'h3f) begin
                    crmd_q[3] <= 1'b1;
                    crmd_q[4] <= 1'b0;
                end
            end else if (is_ertn) begin
                crmd_q[2:0] <= prmd_q;
                if (crmd_q[3] && ecode_q == 6'h3f) begin
                    crmd_q[3] <= 1'b0;
                    crmd_q[4] <= 1'b1;
                end
                if (klo_q) klo_q <= 1'b0;
                else       llbit_q <= 1'b0;
            end else if (csr_write_en) begin
                case (csr_write_addr)
                    A_CRMD:   crmd_q   <= csr_write_data[8:0];
                    A_PRMD:   prmd_q   <= csr_write_data[2:0];
                    A_ECFG:   ecfg_q   <= csr_write_data[12:0] & 13'h1bff;
                    A_ESTAT:  is_sw_q  <= csr_write_data[1:0];
                    A_ERA:    era_q    <= csr_write_data;
                    A_BADV:   badv_q   <= csr_write_data;
                    A_EENTRY: eentry_q <= csr_write_data[31:6];
                    A_LLBCTL: begin
                        klo_q <= csr_write_data[2];
                        if (csr_write_data[1]) llbit_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // Placed last so a committing LL/SC overrides an LLBCTL clear in the same cycle.
            if (!is_exception && is_llw_scw)
                llbit_q <= llbit_value;
        end
    end

`ifdef CSR_TIMER_EN
    typedef enum logic [1:0] {T_IDLE, T_RUN, T_EXPIRED} timer_state_t;
    timer_state_t       t_state;
    timer_state_t       t_next;
    logic [TIMER_W-1:0] tval_next;
    logic               fire;
    logic               tcfg_wr;
    logic               ticlr_wr;

    assign tcfg_wr  = csr_wr && (csr_write_addr == A_TCFG);
    assign ticlr_wr = csr_wr && (csr_write_addr == A_TICLR) && csr_write_data[0];

    always_comb begin
        t_next    = t_state;
        tval_next = tval_r;
        fire      = 1'b0;
        if (tcfg_wr) begin
            tval_next = {csr_write_data[TIMER_W-1:2], 2'b00};
            t_next    = csr_write_data[0] ? T_RUN : T_IDLE;
        end else if (t_state == T_RUN) begin
            if (tval_r != '0) begin
                tval_next = tval_r - 1'b1;
            end else begin
                fire = 1'b1;
                if (tcfg_r[1]) begin
                    tval_next = {tcfg_r[TIMER_W-1:2], 2'b00};
                end else begin
                    tval_next = '1;
                    t_next    = T_EXPIRED;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_state  <= T_IDLE;
            tval_r   <= '0;
            tcfg_r   <= '0;
            tid_r    <= TID_RESET;
            timer_is <= 1'b0;
        end else begin
            t_state <= t_next;
            tval_r  <= tval_next;
            if (tcfg_wr) tcfg_r <= csr_write_data[TIMER_W-1:0];
            if (csr_wr && csr_write_addr == A_TID) tid_r <= csr_write_data;
            // A fire and a TICLR in the same cycle leave the interrupt pending.
            if (fire)          timer_is <= 1'b1;
            else if (ticlr_wr) timer_is <= 1'b0;
        end
    end
`else
    logic [31:0] unused_tid_reset;
    assign unused_tid_reset = TID_RESET;
    assign tid_r    = '0;
    assign tcfg_r   = '0;
    assign tval_r   = '0;
    assign timer_is = 1'b0;
`endif

    assign crmd   = {23'b0, crmd_q};
    assign ecfg   = {19'b0, ecfg_q};
    assign estat  = {1'b0, esub_q, ecode_q, 3'b000, 1'b0, timer_is, 1'b0, is_hw_q, is_sw_q};
    assign era    = era_q;
    assign eentry = {eentry_q, 6'b0};
    assign llbit  = llbit_q;

    always_comb begin
        csr_read_data = '0;
        case (csr_read_addr)
            A_CRMD:   csr_read_data = crmd;
            A_PRMD:   csr_read_data = {29'b0, prmd_q};
            A_ECFG:   csr_read_data = ecfg;
            A_ESTAT:  csr_read_data = estat;
            A_ERA:    csr_read_data = era;
            A_BADV:   csr_read_data = badv_q;
            A_EENTRY: csr_read_data = eentry;
            A_TID:    csr_read_data = tid_r;
            A_TCFG:   csr_read_data = 32'(tcfg_r);
            A_TVAL:   csr_read_data = 32'(tval_r);
            A_LLBCTL: csr_read_data = {29'b0, klo_q, 1'b0, llbit_q};
            default:  csr_read_data = '0;
        endcase
    end
endmodule

// File: tb/tb_csr_trap.sv
// tb_csr_trap: directed vectors for csr_trap with an expected-value queue and negedge monitor.
// Timer vectors run only when CSR_TIMER_EN is defined; otherwise the timer CSRs must read 0.
module tb_csr_trap;
    localparam logic [13:0] A_CRMD   = 14'h000;
    localparam logic [13:0] A_PRMD   = 14'h001;
    localparam logic [13:0] A_ECFG   = 14'h004;
    localparam logic [13:0] A_ESTAT  = 14'h005;
    localparam logic [13:0] A_ERA    = 14'h006;
    localparam logic [13:0] A_BADV   = 14'h007;
    localparam logic [13:0] A_EENTRY = 14'h00c;
    localparam logic [13:0] A_TID    = 14'h040;
    localparam logic [13:0] A_TCFG   = 14'h041;
    localparam logic [13:0] A_TVAL   = 14'h042;
    localparam logic [13:0] A_TICLR  = 14'h044;
    localparam logic [13:0] A_LLBCTL = 14'h060;
    localparam logic [1:0]  S_RD  = 2'd0;
    localparam logic [1:0]  S_LL  = 2'd1;
    localparam logic [1:0]  S_IRQ = 2'd2;
    localparam logic [1:0]  S_TI  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] csr_read_addr;
    logic [31:0] csr_read_data;
    logic        csr_write_en;
    logic [13:0] csr_write_addr;
    logic [31:0] csr_write_data;
    logic        is_exception;
    logic [31:0] exception_pc;
    logic [31:0] exception_addr;
    logic [5:0]  exception_cause;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        is_ertn;
    logic        is_llw_scw;
    logic        llbit_value;
    logic [7:0]  hw_int;
    logic [31:0] crmd, ecfg, estat, era, eentry;
    logic        llbit;

    csr_trap #(.TIMER_W(32), .TID_RESET(32'h0), .EXC_W(6)) dut (
        .clk(clk), .rst(rst),
        .csr_read_addr(csr_read_addr), .csr_read_data(csr_read_data),
        .csr_write_en(csr_write_en), .csr_write_addr(csr_write_addr),
        .csr_write_data(csr_write_data),
        .is_exception(is_exception), .exception_pc(exception_pc),
        .exception_addr(exception_addr), .exception_cause(exception_cause),
        .ecode(ecode), .esubcode(esubcode),
        .is_ertn(is_ertn), .is_llw_scw(is_llw_scw), .llbit_value(llbit_value),
        .hw_int(hw_int),
        .crmd(crmd), .ecfg(ecfg), .estat(estat), .era(era), .eentry(eentry),
        .llbit(llbit)
    );

    always #5 clk = ~clk;

    // Scoreboard: driver pushes expectation and selector; monitor pops on each chk_valid cycle.
    logic [31:0] exp_q[$];
    logic [1:0]  sel_q[$];
    string       name_q[$];
    logic        chk_valid;
    int          checks = 0;
    int          passed = 0;
    logic [31:0] mon_exp;
    logic [31:0] mon_act;
    logic [1:0]  mon_sel;
    string       mon_name;

    function automatic logic [31:0] observe(input logic [1:0] sel);
        case (sel)
            S_RD:    return csr_read_data;
            S_LL:    return {31'b0, llbit};
            S_IRQ:   return {31'b0, crmd[2] & (|(estat[12:0] & ecfg[12:0]))};
            default: return {31'b0, estat[11]};
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL monitor_underflow: got no entry, required one queued expectation");
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_sel  = sel_q.pop_front();
                mon_name = name_q.pop_front();
                mon_act  = observe(mon_sel);
                if (mon_act === mon_exp) passed++;
                else $display("FAIL %s: got %h required %h", mon_name, mon_act, mon_exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input logic [1:0] sel, input logic [13:0] addr,
                       input logic [31:0] exp, input string name);
        csr_read_addr = addr;
        exp_q.push_back(exp);
        sel_q.push_back(sel);
        name_q.push_back(name);
        chk_valid = 1'b1;
        tick(1);
        chk_valid = 1'b0;
    endtask

    task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
        csr_write_en   = 1'b1;
        csr_write_addr = a;
        csr_write_data = d;
        tick(1);
        csr_write_en   = 1'b0;
    endtask

    task automatic take_exc(input logic [31:0] pc, input logic [31:0] addr,
                            input logic [5:0] cause, input logic [5:0] code);
        is_exception    = 1'b1;
        exception_pc    = pc;
        exception_addr  = addr;
        exception_cause = cause;
        ecode           = code;
        esubcode        = 9'h0;
        tick(1);
        is_exception    = 1'b0;
    endtask

    task automatic do_ertn();
        is_ertn = 1'b1;
        tick(1);
        is_ertn = 1'b0;
    endtask

    task automatic llsc(input logic v);
        is_llw_scw  = 1'b1;
        llbit_value = v;
        tick(1);
        is_llw_scw  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; chk_valid = 1'b0;
        csr_read_addr = '0; csr_write_en = 1'b0; csr_write_addr = '0; csr_write_data = '0;
        is_exception = 1'b0; exception_pc = '0; exception_addr = '0; exception_cause = '0;
        ecode = '0; esubcode = '0; is_ertn = 1'b0; is_llw_scw = 1'b0; llbit_value = 1'b0;
        hw_int = '0;
        tick(3);
        rst = 1'b0;

        chk(S_RD, A_CRMD,  32'h8, "rst_crmd");
        chk(S_RD, A_ESTAT, 32'h0, "rst_estat");
        chk(S_RD, A_ERA,   32'h0, "rst_era");
        chk(S_LL, A_CRMD,  32'h0, "rst_llbit");
        chk(S_RD, A_TID,   32'h0, "rst_tid");

        // ALE entry from PLV3/IE=1
        csr_wr(A_CRMD, 32'h7);
        take_exc(32'h1c000100, 32'h1234, 6'd9, 6'h9);
        chk(S_RD, A_PRMD,  32'h7,        "exc_prmd");
        chk(S_RD, A_CRMD,  32'h0,        "exc_crmd");
        chk(S_RD, A_ERA,   32'h1c000100, "exc_era");
        chk(S_RD, A_BADV,  32'h1234,     "exc_badv_ale");
        chk(S_RD, A_ESTAT, 32'h00090000, "exc_estat");

        llsc(1'b1);
        chk(S_LL, A_CRMD, 32'h1, "llw_set");
        do_ertn();
        chk(S_RD, A_CRMD, 32'h7, "ertn_crmd");
        chk(S_LL, A_CRMD, 32'h0, "ertn_llbit_clr");

        // KLO keeps LLbit across one ertn and self-clears
        llsc(1'b1);
        csr_wr(A_LLBCTL, 32'h4);
        chk(S_RD, A_LLBCTL, 32'h5, "llbctl_klo");
        do_ertn();
        chk(S_LL, A_CRMD,   32'h1, "ertn_klo_llbit");
        chk(S_RD, A_LLBCTL, 32'h1, "ertn_klo_clr");

        // write and sc.w coincide with an exception: both dropped
        csr_write_en = 1'b1; csr_write_addr = A_ERA; csr_write_data = 32'hdead;
        is_llw_scw = 1'b1; llbit_value = 1'b0;
        take_exc(32'h80, 32'h9999, 6'd0, 6'h0);
        csr_write_en = 1'b0; is_llw_scw = 1'b0;
        chk(S_RD, A_ERA,  32'h80,   "exc_beats_write");
        chk(S_RD, A_BADV, 32'h1234, "badv_unchanged");
        chk(S_LL, A_CRMD, 32'h1,    "exc_beats_llsc");

        // TLBR entry/return toggles DA/PG
        take_exc(32'h300, 32'h0, 6'd0, 6'h3f);
        chk(S_RD, A_CRMD, 32'h8, "tlbr_crmd");
        do_ertn();
        chk(S_RD, A_CRMD, 32'h10, "tlbr_ertn_crmd");
        chk(S_LL, A_CRMD, 32'h0,  "tlbr_ertn_llbit");

        take_exc(32'h2000, 32'h5555, 6'd8, 6'h8);
        chk(S_RD, A_BADV,  32'h2000,     "badv_adef");
        chk(S_RD, A_ESTAT, 32'h00080000, "estat_adef");
        take_exc(32'h2100, 32'h6666, 6'd10, 6'h8);
        chk(S_RD, A_BADV,  32'h6666,     "badv_adem");

        // write masks and unmapped address
        csr_wr(A_ECFG, 32'hffffffff);
        chk(S_RD, A_ECFG, 32'h00001bff, "mask_ecfg");
        csr_wr(A_ESTAT, 32'hffffffff);
        chk(S_RD, A_ESTAT, 32'h00080003, "mask_estat");
        csr_wr(A_EENTRY, 32'hffffffff);
        chk(S_RD, A_EENTRY, 32'hffffffc0, "mask_eentry");
        csr_wr(A_PRMD, 32'hffffffff);
        chk(S_RD, A_PRMD, 32'h7, "mask_prmd");
        csr_wr(14'h003, 32'hffffffff);
        chk(S_RD, 14'h003, 32'h0, "unmapped");

        // hw interrupt latching and pending view
        csr_wr(A_ESTAT, 32'h0);
        csr_wr(A_CRMD, 32'h4);
        chk(S_IRQ, A_CRMD, 32'h0, "irq_idle");
        hw_int = 8'h01;
        chk(S_RD, A_ESTAT, 32'h00080000, "hw_int_not_comb");
        chk(S_RD, A_ESTAT, 32'h00080004, "hw_int_latched");
        chk(S_IRQ, A_CRMD, 32'h1,        "irq_pending");
        hw_int = 8'h00;
        tick(1);
        chk(S_RD, A_ESTAT, 32'h00080000, "hw_int_drop");

`ifdef CSR_TIMER_EN
        csr_wr(A_TID, 32'habcd1234);
        chk(S_RD, A_TID, 32'habcd1234, "tid_write");
        csr_wr(A_TCFG, 32'h7);
        chk(S_RD, A_TVAL, 32'h4, "tval_4");
        chk(S_RD, A_TVAL, 32'h3, "tval_3");
        chk(S_RD, A_TVAL, 32'h2, "tval_2");
        chk(S_RD, A_TVAL, 32'h1, "tval_1");
        chk(S_RD, A_TVAL, 32'h0, "tval_0");
        chk(S_RD, A_TVAL, 32'h4, "tval_reload");
        chk(S_TI, A_CRMD, 32'h1, "ti_fire");
        csr_wr(A_TICLR, 32'h1);
        chk(S_TI, A_CRMD, 32'h0, "ticlr");
        // TVAL is 0 here: the TCFG write must win over the fire
        csr_wr(A_TCFG, 32'h5);
        chk(S_TI, A_CRMD, 32'h0, "tcfg_wins");
        chk(S_RD, A_TVAL, 32'h3, "oneshot_3");
        tick(3);
        chk(S_RD, A_TVAL, 32'hffffffff, "oneshot_expire");
        chk(S_RD, A_TVAL, 32'hffffffff, "oneshot_hold");
        chk(S_TI, A_CRMD, 32'h1,        "oneshot_fire");
        chk(S_RD, A_TCFG, 32'h5,        "tcfg_read");
        csr_wr(A_TCFG, 32'h7);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk(S_RD, A_TVAL, 32'h0, "rst_mid_tval");
        chk(S_TI, A_CRMD, 32'h0, "rst_mid_ti");
        tick(6);
        chk(S_RD, A_TVAL, 32'h0, "idle_hold");
`else
        csr_wr(A_TID, 32'habcd1234);
        chk(S_RD, A_TID, 32'h0, "tid_absent");
        csr_wr(A_TCFG, 32'h7);
        chk(S_RD, A_TCFG, 32'h0, "tcfg_absent");
        tick(6);
        chk(S_RD, A_TVAL, 32'h0, "tval_absent");
        chk(S_TI, A_CRMD, 32'h0, "ti_absent");
`endif

        tick(2);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
